// File: rtl/crypt_stream_ctrl.sv
// Burst sequencer for the Crypt XOR datapath: streams words through one
// Crypt instance with an optional per-word rolling key.
module crypt_xor (
    input  logic [31:0] data_i,
    input  logic [31:0] key_i,
    output logic [31:0] data_o
);
    assign data_o = data_i ^ key_i;
endmodule

module crypt_stream_ctrl #(
    parameter int LEN_W = 16,
    parameter int ROT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_key_we,
    input  logic [31:0]      cfg_key,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_last
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    // LS wraps to 0 when RS is 0 so the rotate degenerates to w | w.
    localparam int unsigned RS = ROT % 32;
    localparam int unsigned LS = (32 - RS) % 32;

    state_e           state_q, state_d;
    logic [31:0]      base_key_q, base_key_d;
    logic [31:0]      wkey_q, wkey_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             m_valid_q, m_valid_d;
    logic [31:0]      m_data_q, m_data_d;
    logic             m_last_q, m_last_d;

    logic [31:0] crypt_out;
    logic [31:0] wkey_rot;
    logic        accept;
    logic        is_last;

    crypt_xor u_crypt (
        .data_i (s_data),
        .key_i  (wkey_q),
        .data_o (crypt_out)
    );

    assign wkey_rot = (wkey_q << RS) | (wkey_q >> LS);
    assign s_ready  = (state_q == RUN) && (!m_valid_q || m_ready);
    assign accept   = s_valid && s_ready;
    assign is_last  = (cnt_q == LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        base_key_d = base_key_q;
        wkey_d     = wkey_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_key_we) begin
                    base_key_d = cfg_key;
                end
                // Start latches the key held before any same-cycle write.
                if (start) begin
                    if (length != '0) begin
                        state_d = RUN;
                        cnt_d   = length;
                        wkey_d  = base_key_q;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                end
                if (accept) begin
                    m_data_d  = crypt_out;
                    m_valid_d = 1'b1;
                    m_last_d  = is_last;
                    cnt_d     = cnt_q - LEN_W'(1);
                    wkey_d    = wkey_rot;
                    if (is_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        m_last_d = 1'b0;
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_key_q <= '0;
            wkey_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_key_q <= base_key_d;
            wkey_q     <= wkey_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
endmodule
